// File: rtl/hist_pkg.sv
// Shared types and helpers for the streaming histogram engine.
// Holds the state encoding, bin-index extraction and saturating increment.
package hist_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_READ  = 1'b1
  } hist_state_t;

  // Top bin_bits of a data_w-wide sample (sample is zero-extended into 64 bits).
  function automatic logic [31:0] bin_index(input logic [63:0] sample,
                                            input int        data_w,
                                            input int        bin_bits);
    logic [63:0] shifted;
    logic [63:0] mask;
    shifted = sample >> (data_w - bin_bits);
    mask    = (64'd1 << bin_bits) - 64'd1;
    return 32'(shifted & mask);
  endfunction

  // Compare against all-ones first so a count_w-wide counter never wraps.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input int        count_w);
    logic [63:0] max_v;
    logic [63:0] result;
    max_v = (64'd1 << count_w) - 64'd1;
    if (value >= max_v) begin
      result = max_v;
    end else begin
      result = value + 64'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hist_sat_counter.sv
// One histogram bin: saturating up-counter with clear priority over increment.
module hist_sat_counter
  import hist_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] count,
  output logic               sat_hit
);

  logic [COUNT_W-1:0] count_r;

  assign count   = count_r;
  // Flags an increment that was swallowed because the bin is already full.
  assign sat_hit = inc & ~clr & (count_r == {COUNT_W{1'b1}});

  // Bin counter update: clear, saturating increment, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {COUNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {COUNT_W{1'b0}};
    end else if (inc) begin
      count_r <= COUNT_W'(sat_inc(64'(count_r), COUNT_W));
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/histogram_stream.sv
// Streaming histogram: bins samples by their top bits into saturating counters,
// then drains every bin over a valid/ready stream, clearing each bin as it is read.
module histogram_stream
  import hist_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int BIN_BITS = 4,
  parameter int COUNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               write_en,
  input  logic               start_read,
  output logic               ready,
  output logic [COUNT_W-1:0] data_out,
  output logic               valid_out,
  input  logic               out_ready,
  output logic               last_bin,
  output logic               overflow
);

  localparam int NUM_BINS = 2 ** BIN_BITS;
  localparam logic [BIN_BITS-1:0] LAST_IDX = {BIN_BITS{1'b1}};

  hist_state_t         state_r;
  logic [BIN_BITS-1:0] rd_idx_r;
  logic [BIN_BITS-1:0] next_idx_s;
  logic [BIN_BITS-1:0] wr_idx_s;
  logic                accept_s;
  logic                handshake_s;
  logic [NUM_BINS-1:0] inc_s;
  logic [NUM_BINS-1:0] clr_s;
  logic [NUM_BINS-1:0] sat_hit_s;
  logic [COUNT_W-1:0]  count_s [NUM_BINS];
  logic [COUNT_W-1:0]  rd_count_s;
  logic [COUNT_W-1:0]  next_count_s;

  assign ready        = (state_r == ST_ACCUM);
  assign wr_idx_s     = BIN_BITS'(bin_index(64'(data_in), DATA_W, BIN_BITS));
  assign accept_s     = (state_r == ST_ACCUM) & write_en;
  assign handshake_s  = (state_r == ST_READ) & valid_out & out_ready;
  assign next_idx_s   = rd_idx_r + BIN_BITS'(1);
  assign rd_count_s   = count_s[rd_idx_r];
  assign next_count_s = count_s[next_idx_s];

  for (genvar b = 0; b < NUM_BINS; b++) begin : g_bin
    assign inc_s[b] = accept_s & (wr_idx_s == BIN_BITS'(b));
    assign clr_s[b] = handshake_s & (rd_idx_r == BIN_BITS'(b));

    hist_sat_counter #(
      .COUNT_W (COUNT_W)
    ) u_bin (
      .clk     (clk),
      .rst     (reset),
      .inc     (inc_s[b]),
      .clr     (clr_s[b]),
      .count   (count_s[b]),
      .sat_hit (sat_hit_s[b])
    );
  end

  // Control FSM with registered stream outputs and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_ACCUM;
      rd_idx_r  <= {BIN_BITS{1'b0}};
      data_out  <= {COUNT_W{1'b0}};
      valid_out <= 1'b0;
      last_bin  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          valid_out <= 1'b0;
          last_bin  <= 1'b0;
          if (|sat_hit_s) begin
            overflow <= 1'b1;
          end else begin
            overflow <= overflow;
          end
          if (start_read) begin
            state_r  <= ST_READ;
            rd_idx_r <= {BIN_BITS{1'b0}};
          end else begin
            state_r  <= ST_ACCUM;
            rd_idx_r <= rd_idx_r;
          end
        end
        ST_READ: begin
          // First READ cycle loads bin 0; any same-cycle sample has already landed.
          if (!valid_out) begin
            data_out  <= rd_count_s;
            valid_out <= 1'b1;
            last_bin  <= (rd_idx_r == LAST_IDX);
          end else if (out_ready) begin
            if (last_bin) begin
              state_r   <= ST_ACCUM;
              valid_out <= 1'b0;
              last_bin  <= 1'b0;
              overflow  <= 1'b0;
            end else begin
              rd_idx_r <= next_idx_s;
              data_out <= next_count_s;
              last_bin <= (next_idx_s == LAST_IDX);
            end
          end else begin
            data_out  <= data_out;
            valid_out <= valid_out;
            last_bin  <= last_bin;
          end
        end
        default: begin
          state_r   <= ST_ACCUM;
          rd_idx_r  <= {BIN_BITS{1'b0}};
          valid_out <= 1'b0;
          last_bin  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/histogram_stream.md
# histogram_stream

Parametrised streaming histogram engine: bins incoming samples by their top `BIN_BITS` bits into `2**BIN_BITS` saturating counters. On request, it drains all bins over a valid/ready output stream and clears each bin as it is read. It generalises the fixed 16-bit/8-bit histogrammer with configurable data, bin and count widths, output back-pressure, saturation reporting and clear-on-read. It sits between the sample input pads and the readout/serialiser logic of the top-level wrapper.

## Interface
Parameters:
- `DATA_W`, 16: sample width.
- `BIN_BITS`, 4: bin index width; `NUM_BINS = 2**BIN_BITS`; must satisfy `BIN_BITS <= DATA_W`.
- `COUNT_W`, 8: per-bin counter width; saturates at `2**COUNT_W-1`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `data_in` in `DATA_W`: sample; bin index = `data_in[DATA_W-1 -: BIN_BITS]`.
- `write_en` in 1: sample strobe, one sample per cycle.
- `start_read` in 1: request a full drain of all bins.
- `ready` out 1: high while in ACCUM (samples accepted).
- `data_out` out `COUNT_W`: bin count of the current beat.
- `valid_out` out 1: beat valid.
- `out_ready` in 1: downstream accepts the beat.
- `last_bin` out 1: current beat is bin `NUM_BINS-1`.
- `overflow` out 1: sticky; some bin saturated since the last completed drain.

## Operation
- States: ACCUM (the reset state) and READ.
- **ACCUM:**
  - `write_en=1` increments `bin[idx]` by 1, saturating. An attempted increment at max leaves the bin at max and sets `overflow`.
  - `start_read=1` moves to READ and loads `rd_idx=0`.
  - If `write_en` and `start_read` are both high in the same cycle, the sample is counted first and is included in the drain.
- **READ:**
  - `write_en` is ignored; samples are dropped with no side effect.
  - `start_read` is ignored.
  - Beat k presents `bin[k]`. A handshake (`valid_out & out_ready`) zeroes `bin[k]` and advances to k+1.
  - `data_out`, `valid_out` and `last_bin` hold stable while `valid_out & ~out_ready`.
  - The handshake on the `last_bin` beat clears `overflow` and returns to ACCUM.
- Reset mid-operation: all bins 0, `overflow` 0, state ACCUM. An in-flight drain is abandoned with no partial beat output.
- Arithmetic: compare against all-ones before incrementing, so the counter never wraps.

## Timing
- Reset values: `data_out=0`, `valid_out=0`, `last_bin=0`, `overflow=0`, `ready=1`.
- `ready` is decoded combinationally from the state register.
- Increment latency: a sample at edge t is visible in the bin at t+1. A following read sees it.
- Read latency: `start_read` sampled at edge t gives `valid_out=1` with `bin[0]` after edge t+1. `ready` drops after edge t.
- Throughput: with `out_ready` held high, one beat per cycle; a drain takes exactly `NUM_BINS` cycles.
- After the final handshake at edge t: `valid_out=0`, `last_bin=0`, `ready=1` after edge t. Samples are accepted from edge t+1.
- `data_out`, `valid_out` and `last_bin` are registered outputs with no combinational path from `out_ready`.
- Back-to-back: `start_read` at the cycle `ready` returns high starts a new drain normally.

## Structure
- Package `hist_pkg` holds:
  - the state typedef `hist_state_t {ST_ACCUM, ST_READ}`;
  - a `bin_index` function (top-bits extraction);
  - a `sat_inc` function, parameterised by `COUNT_W`.
- One sub-module `hist_sat_counter` (`COUNT_W` parameter), with inputs `inc` and `clr` and outputs `count` and `sat_hit`. It is instantiated `NUM_BINS` times in a generate loop.
- `clr` has priority over `inc`. The two cannot coincide in practice, because `inc` is ACCUM-only and `clr` is READ-only.

## Test plan
All scenarios use defaults (16/4/8).
- Write `0x3000` ×3 and `0xF123` ×1, then drain → beats 0..15 read 0,0,0,3,0,…,0,1. `last_bin` is high only on beat 15, and a second drain reads all zeros.
- Write `0x5000` ×300, then drain → `bin[5]=255`. `overflow` is 1 until the last handshake, then 0.
- Drain with `out_ready` toggling 1,0,0,1,… → every beat is delivered exactly once, and `data_out` is stable across stalls. Total beats = 16.
- `write_en=1` with `0x2000` in the same cycle as `start_read`, then `0x2000` writes during READ → drain shows `bin[2]=1`, and the writes during READ are not counted afterwards.
- Pulse `reset` after beat 6 of a drain → outputs go to reset values asynchronously, and a new drain reads all zeros.
- `start_read` asserted on the first cycle `ready` returns → `valid_out` rises the next cycle with `bin[0]`.
